// File: rtl/puf_pkg.sv
// puf_pkg: shared types and elaboration helpers for the PUF response collector.
//   state_e      - collector FSM states (IDLE..DONE)
//   cnt_w()      - width of a counter that must hold 0..max_val
//   params_ok()  - legality of VOTES / SETTLE_CYCLES / RESP_BITS
package puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RACE,
        SAMPLE,
        DECIDE,
        DONE
    } state_e;

    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    // VOTES must be odd so the majority is never tied; SETTLE_CYCLES must
    // cover the 2-flop synchroniser latency plus one cycle of margin.
    function automatic bit params_ok(input int votes, input int settle, input int resp_bits);
        return (votes >= 1) && (votes <= 15) && ((votes % 2) == 1) &&
               (settle >= 3) && (resp_bits >= 1) && (resp_bits <= 32);
    endfunction

endpackage

// File: rtl/puf_response_collector_if.sv
// puf_response_collector_if: host-side request/response bundle.
//   start, challenge_seed  - run request and base challenge (host -> collector)
//   busy                   - collector not idle
//   resp_valid, resp_ready - response handshake
//   response               - assembled response word
//   unstable               - per-bit non-unanimous flag (PUF_UNSTABLE_FLAG_EN only)
// Modports: master = host, slave = collector.
interface puf_response_collector_if #(
    parameter int RESP_BITS = 8,
    parameter int CHAL_W    = 8
);
    logic                 start;
    logic [CHAL_W-1:0]    challenge_seed;
    logic                 busy;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [RESP_BITS-1:0] response;
`ifdef PUF_UNSTABLE_FLAG_EN
    logic [RESP_BITS-1:0] unstable;

    modport master (output start, challenge_seed, resp_ready,
                    input  busy, resp_valid, response, unstable);
    modport slave  (input  start, challenge_seed, resp_ready,
                    output busy, resp_valid, response, unstable);
`else
    modport master (output start, challenge_seed, resp_ready,
                    input  busy, resp_valid, response);
    modport slave  (input  start, challenge_seed, resp_ready,
                    output busy, resp_valid, response);
`endif
endinterface

// File: rtl/puf_sync2.sv
// puf_sync2: 2-flop synchroniser, async active-high reset to 0.
//   clk, rst - clock / reset
//   d        - asynchronous input
//   q        - synchronised output (2 cycles latency)
module puf_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb sync_d = {sync_q[0], d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end

    assign q = sync_q[1];
endmodule

// File: rtl/puf_response_collector.sv
// puf_response_collector: drives a race_arbiter, repeats each race VOTES
// times, majority-votes the synchronised arbiter output per bit and
// assembles RESP_BITS bits into a response handed over valid/ready.
//   clk, rst      - clock, async active-high reset
//   host          - request/response bundle (slave modport)
//   arb_enable    - race enable to the arbiter
//   arb_challenge - seed + bit index, wraps modulo 2^CHAL_W
//   arb_out       - arbiter result, asynchronous to clk
// Optional: PUF_UNSTABLE_FLAG_EN adds host.unstable (non-unanimous vote flags).
//
// state  | meaning
// IDLE   | waiting for start; response held from previous run
// ARM    | enable low SETTLE_CYCLES cycles, race path reset
// RACE   | enable high SETTLE_CYCLES cycles, race resolves and syncs
// SAMPLE | enable high, count one vote
// DECIDE | majority into response[bit_idx], next bit or finish
// DONE   | resp_valid high until accepted
module puf_response_collector
    import puf_pkg::*;
#(
    parameter int RESP_BITS     = 8,
    parameter int VOTES         = 5,
    parameter int SETTLE_CYCLES = 4,
    parameter int CHAL_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    puf_response_collector_if.slave host,
    output logic                  arb_enable,
    output logic [CHAL_W-1:0]     arb_challenge,
    input  logic                  arb_out
);
    localparam int VOTE_W   = cnt_w(VOTES);
    localparam int BIT_W    = cnt_w(RESP_BITS - 1);
    localparam int SETTLE_W = cnt_w(SETTLE_CYCLES - 1);

    localparam logic [VOTE_W-1:0]   VOTES_V     = VOTE_W'(VOTES);
    localparam logic [VOTE_W-1:0]   HALF_V      = VOTE_W'(VOTES / 2);
    localparam logic [BIT_W-1:0]    LAST_BIT    = BIT_W'(RESP_BITS - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    if (!params_ok(VOTES, SETTLE_CYCLES, RESP_BITS)) begin : g_param_err
        $error("puf_response_collector: illegal VOTES/SETTLE_CYCLES/RESP_BITS");
    end

    state_e                state_q, state_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic [VOTE_W-1:0]     vote_q, vote_d;
    logic [VOTE_W-1:0]     ones_q, ones_d;
    logic [VOTE_W-1:0]     vote_next;
    logic [BIT_W-1:0]      bit_idx_q, bit_idx_d;
    logic [CHAL_W-1:0]     seed_q, seed_d;
    logic [RESP_BITS-1:0]  response_q, response_d;
    logic                  arb_sync;
`ifdef PUF_UNSTABLE_FLAG_EN
    logic [RESP_BITS-1:0]  unstable_q, unstable_d;
`endif

    puf_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (arb_out),
        .q   (arb_sync)
    );

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        vote_d     = vote_q;
        ones_d     = ones_q;
        bit_idx_d  = bit_idx_q;
        seed_d     = seed_q;
        response_d = response_q;
        vote_next  = vote_q + 1'b1;
`ifdef PUF_UNSTABLE_FLAG_EN
        unstable_d = unstable_q;
`endif
        case (state_q)
            IDLE: begin
                if (host.start) begin
                    seed_d     = host.challenge_seed;
                    bit_idx_d  = '0;
                    response_d = '0;
`ifdef PUF_UNSTABLE_FLAG_EN
                    unstable_d = '0;
`endif
                    settle_d   = SETTLE_LOAD;
                    state_d    = ARM;
                end
            end
            ARM: begin
                if (settle_q == '0) begin
                    settle_d = SETTLE_LOAD;
                    state_d  = RACE;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            RACE: begin
                if (settle_q == '0) state_d  = SAMPLE;
                else                settle_d = settle_q - 1'b1;
            end
            SAMPLE: begin
                vote_d = vote_next;
                if (arb_sync) ones_d = ones_q + 1'b1;
                if (vote_next < VOTES_V) begin
                    settle_d = SETTLE_LOAD;
                    state_d  = ARM;
                end else begin
                    state_d  = DECIDE;
                end
            end
            DECIDE: begin
                response_d[bit_idx_q] = (ones_q > HALF_V);
`ifdef PUF_UNSTABLE_FLAG_EN
                unstable_d[bit_idx_q] = (ones_q != '0) && (ones_q != VOTES_V);
`endif
                vote_d = '0;
                ones_d = '0;
                if (bit_idx_q == LAST_BIT) begin
                    state_d = DONE;
                end else begin
                    bit_idx_d = bit_idx_q + 1'b1;
                    settle_d  = SETTLE_LOAD;
                    state_d   = ARM;
                end
            end
            DONE: begin
                if (host.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            settle_q   <= '0;
            vote_q     <= '0;
            ones_q     <= '0;
            bit_idx_q  <= '0;
            seed_q     <= '0;
            response_q <= '0;
`ifdef PUF_UNSTABLE_FLAG_EN
            unstable_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            vote_q     <= vote_d;
            ones_q     <= ones_d;
            bit_idx_q  <= bit_idx_d;
            seed_q     <= seed_d;
            response_q <= response_d;
`ifdef PUF_UNSTABLE_FLAG_EN
            unstable_q <= unstable_d;
`endif
        end
    end

    assign arb_enable      = (state_q == RACE) || (state_q == SAMPLE);
    assign arb_challenge   = seed_q + CHAL_W'(bit_idx_q);
    assign host.busy       = (state_q != IDLE);
    assign host.resp_valid = (state_q == DONE);
    assign host.response   = response_q;
`ifdef PUF_UNSTABLE_FLAG_EN
    assign host.unstable   = unstable_q;
`endif
endmodule

// File: tb/tb_puf_response_collector.sv
module tb_puf_response_collector;
    localparam int LATENCY = 368;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       arb_enable;
    logic [7:0] arb_challenge;
    logic       arb_out = 1'b0;

    puf_response_collector_if #(.RESP_BITS(8), .CHAL_W(8)) hif ();

    puf_response_collector #(
        .RESP_BITS(8), .VOTES(5), .SETTLE_CYCLES(4), .CHAL_W(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .host          (hif),
        .arb_enable    (arb_enable),
        .arb_challenge (arb_challenge),
        .arb_out       (arb_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Arbiter model: per run, bit b wins (outputs 1) in the first
    // ones_for_bit(mode, b) of its 5 races.
    logic [7:0] cur_seed = 8'h00;
    int         cur_mode = 0;
    int         race_cnt = 0;
    int         low_run  = 0;
    int         high_run = 0;
    logic       en_prev  = 1'b0;

    function automatic int ones_for_bit(input int mode, input int b);
        case (mode)
            0:       return 5;
            1:       return (b % 2 == 0) ? 3 : 2;
            2:       return 0;
            default: return b % 6;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst || !hif.busy) begin
            race_cnt = 0;
            low_run  = 0;
            high_run = 0;
            arb_out  = 1'b0;
            en_prev  = arb_enable;
        end else begin
            if (arb_enable && !en_prev) begin
                int b, r;
                race_cnt++;
                b = (race_cnt - 1) / 5;
                r = (race_cnt - 1) % 5;
                // first race of a later bit also sees the DECIDE cycle low
                chk("arb_low_cycles", low_run, (r == 0 && b != 0) ? 5 : 4);
                chk("arb_challenge", arb_challenge, 8'(cur_seed + b));
                arb_out  = (r < ones_for_bit(cur_mode, b));
                high_run = 1;
                low_run  = 0;
            end else if (arb_enable) begin
                high_run++;
            end else begin
                if (en_prev) chk("arb_high_cycles", high_run, 5);
                low_run++;
                arb_out = 1'b0;
            end
            en_prev = arb_enable;
        end
    end

    task automatic do_start(input logic [7:0] seed, input int mode);
        @(negedge clk);
        cur_seed           = seed;
        cur_mode           = mode;
        hif.challenge_seed = seed;
        hif.start          = 1'b1;
        @(negedge clk);
        hif.start = 1'b0;
        chk("busy_after_start", hif.busy, 1);
    endtask

    task automatic run_and_check(input logic [7:0] seed, input int mode,
                                 input logic [7:0] exp_resp, input logic [7:0] exp_unst,
                                 input logic ready_early);
        int n;
        hif.resp_ready = ready_early;
        do_start(seed, mode);
        n = 0;
        while (!hif.resp_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, LATENCY);
        chk("resp_valid", hif.resp_valid, 1);
        chk("response", hif.response, exp_resp);
        chk("race_count", race_cnt, 40);
`ifdef PUF_UNSTABLE_FLAG_EN
        chk("unstable", hif.unstable, exp_unst);
`else
        if (exp_unst !== exp_unst) chk("unstable_unused", 0, 1);
`endif
    endtask

    task automatic handshake(input logic [7:0] exp_resp);
        hif.resp_ready = 1'b1;
        @(negedge clk);
        chk("hs_busy", hif.busy, 0);
        chk("hs_valid", hif.resp_valid, 0);
        chk("hs_response_kept", hif.response, exp_resp);
        hif.resp_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] seed;
        int         mode;
        logic [7:0] exp_resp;
        logic [7:0] exp_unst;
        logic       ready_early;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int n;
        vecs[0] = '{seed: 8'h10, mode: 0, exp_resp: 8'hFF, exp_unst: 8'h00, ready_early: 1'b0};
        vecs[1] = '{seed: 8'hFE, mode: 1, exp_resp: 8'h55, exp_unst: 8'hFF, ready_early: 1'b0};
        vecs[2] = '{seed: 8'h00, mode: 2, exp_resp: 8'h00, exp_unst: 8'h00, ready_early: 1'b1};
        vecs[3] = '{seed: 8'h80, mode: 3, exp_resp: 8'h38, exp_unst: 8'h9E, ready_early: 1'b0};

        hif.start          = 1'b0;
        hif.challenge_seed = 8'h00;
        hif.resp_ready     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_arb_enable", arb_enable, 0);
        chk("rst_arb_challenge", arb_challenge, 0);
        chk("rst_busy", hif.busy, 0);
        chk("rst_resp_valid", hif.resp_valid, 0);
        chk("rst_response", hif.response, 0);
`ifdef PUF_UNSTABLE_FLAG_EN
        chk("rst_unstable", hif.unstable, 0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_and_check(vecs[i].seed, vecs[i].mode, vecs[i].exp_resp,
                          vecs[i].exp_unst, vecs[i].ready_early);
            handshake(vecs[i].exp_resp);
        end

        // Host stalls 20 cycles; a start pulse in DONE must be ignored.
        run_and_check(8'h33, 0, 8'hFF, 8'h00, 1'b0);
        for (int i = 0; i < 20; i++) begin
            hif.start          = (i == 10);
            hif.challenge_seed = 8'h99;
            @(negedge clk);
            chk("stall_valid", hif.resp_valid, 1);
            chk("stall_response", hif.response, 8'hFF);
        end
        hif.start = 1'b0;
        chk("stall_busy", hif.busy, 1);
        // start coincident with the handshake is not accepted
        hif.start      = 1'b1;
        hif.resp_ready = 1'b1;
        @(negedge clk);
        hif.start      = 1'b0;
        hif.resp_ready = 1'b0;
        chk("hs_start_busy", hif.busy, 0);
        chk("hs_start_response", hif.response, 8'hFF);
        @(negedge clk);
        chk("hs_start_not_taken", hif.busy, 0);

        // Reset during RACE of bit 3, then a clean full run.
        do_start(8'h20, 0);
        n = 0;
        while (race_cnt < 16 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach_bit3", (race_cnt >= 16), 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_arb_enable", arb_enable, 0);
        chk("abort_arb_challenge", arb_challenge, 0);
        chk("abort_busy", hif.busy, 0);
        chk("abort_resp_valid", hif.resp_valid, 0);
        chk("abort_response", hif.response, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_no_valid", hif.resp_valid, 0);
        run_and_check(8'h20, 3, 8'h38, 8'h9E, 1'b0);
        handshake(8'h38);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
